// File: rtl/shift_seq_pkg.sv
// Shared types and sizing for the multi-cycle shift sequencer.
// Imported by the sequencer top and its ari_shift datapath.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_state_t;

  localparam int CHUNK_MAX = 3;
  localparam int AMT_W     = 3;
  localparam int DATA_W    = 8;

endpackage

// File: rtl/ari_shift.sv
// Combinational 8-bit shifter/rotator moving 0-3 positions per pass.
// Right shifts are arithmetic, left shifts fill with zero.
module ari_shift
  import shift_seq_pkg::*;
#(
  parameter int NAND_TIME = 7
) (
  input  logic [DATA_W-1:0] a,
  input  logic              left,
  input  logic              rotate,
  input  logic [1:0]        amt,
  output logic [DATA_W-1:0] c
);

  // Gate delay only matters for timing closure; reject nonsense values.
  if (NAND_TIME <= 0) begin : g_bad_delay
    $error("ari_shift: NAND_TIME must be positive");
  end

  logic [DATA_W-1:0] t;

  always_comb begin
    t = a;
    for (int i = 0; i < CHUNK_MAX; i++) begin
      if (i < int'(amt)) begin
        if (left) begin
          t = {t[DATA_W-2:0], rotate ? t[DATA_W-1] : 1'b0};
        end else begin
          t = {rotate ? t[0] : t[DATA_W-1], t[DATA_W-1:1]};
        end
      end
    end
  end

  assign c = t;

endmodule

// File: rtl/shift_sequencer.sv
// Iterates an operand through ari_shift in chunks of up to 3 positions
// to realise 0-7 position shifts/rotates behind a ready/req handshake.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int NAND_TIME = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] data,
  input  logic              left,
  input  logic              rotate,
  input  logic [AMT_W-1:0]  amt,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  logic              op_left_q, op_left_d;
  logic              op_rot_q, op_rot_d;

  logic [1:0]        chunk;
  logic [AMT_W-1:0]  rem_left;
  logic [DATA_W-1:0] shift_c;

  assign chunk = (rem_q > AMT_W'(CHUNK_MAX))
               ? 2'(CHUNK_MAX) : rem_q[1:0];
  assign rem_left = rem_q - {1'b0, chunk};

  ari_shift #(
    .NAND_TIME(NAND_TIME)
  ) u_ari_shift (
    .a      (acc_q),
    .left   (op_left_q),
    .rotate (op_rot_q),
    .amt    (chunk),
    .c      (shift_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      rem_q     <= '0;
      op_left_q <= 1'b0;
      op_rot_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      op_left_q <= op_left_d;
      op_rot_q  <= op_rot_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    op_left_d = op_left_q;
    op_rot_d  = op_rot_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          acc_d     = data;
          rem_d     = amt;
          op_left_d = left;
          op_rot_d  = rotate;
          state_d   = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_d = shift_c;
        rem_d = rem_left;
        if (rem_left == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign result = acc_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that performs 8-bit arithmetic/logical shifts and rotates by 0–7 positions by repeatedly driving the existing combinational `ari_shift` datapath, which moves at most 3 positions per pass. It accepts one request at a time through a ready/req handshake. It iterates the operand through `ari_shift` in chunks of at most 3, and returns the result with a one-cycle `done` pulse. It sits between the ALU decode logic and the shifter.

## Interface
- `NAND_TIME`, 7ns, gate delay forwarded unchanged to the `ari_shift` instance.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  1  request strobe; accepted only when `ready`=1.
- `data`  input  8  operand, sampled on the accepting edge.
- `left`  input  1  1 = shift/rotate left, 0 = right; sampled on accept.
- `rotate`  input  1  1 = rotate, 0 = shift; sampled on accept.
- `amt`  input  3  total shift distance 0–7; sampled on accept.
- `ready`  output  1  high only in IDLE.
- `done`  output  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  output  8  final value; holds until the next accept or reset.

## Operation
- Shift semantics:
  - Right shift is arithmetic: it fills with the sign bit `acc[7]`.
  - Left shift fills with 0.
  - Rotate wraps the bits around.
  - Because of this, chaining chunks gives exactly the same result as a single shift by `amt`.
- Internal registers:
  - `acc[7:0]`: working operand.
  - `rem[2:0]`: distance still to shift.
  - `op_left`, `op_rot`: latched operation controls.
  - `state`.
- Chunk size: `chunk = (rem > 3) ? 3 : rem[1:0]`. This drives `ari_shift.amt` and is never 0 in SHIFT.
- The `ari_shift` instance is wired as `a = acc`, `left = op_left`, `rotate = op_rot`, `amt = chunk`.
- States and transitions:
  - **IDLE**: `ready`=1. On `req`=1:
    - load `acc <= data`, `rem <= amt`, and latch `left`/`rotate`;
    - go to DONE if `amt`=0, else go to SHIFT.
    - `req` with `ready`=0 is ignored; it is neither queued nor errored.
  - **SHIFT**: each edge does `acc <= ari_shift.c` and `rem <= rem - chunk`. When `rem - chunk == 0`, go to DONE.
  - **DONE**: `done`=1 and `result` = `acc`. The next edge returns to IDLE.
- `result` is combinationally equal to `acc`. `acc` does not change outside SHIFT or an accept, so `result` is stable from `done` until the next accept.
- Input changes during SHIFT/DONE have no effect.
- Reset, including in mid-operation:
  - next state is IDLE;
  - `acc`, `rem`, `op_left`, `op_rot` become 0;
  - outputs after reset: `ready`=1, `done`=0, `result`=0x00.
  - Any in-flight operation is discarded, with no `done`.
  - `rst` has priority over `req` on the same edge.

## Timing
- Accept on edge E0. The number of SHIFT cycles is k = ceil(`amt`/3):
  - k = 0 for `amt` 0;
  - k = 1 for `amt` 1–3;
  - k = 2 for `amt` 4–6;
  - k = 3 for `amt` 7 (chunks 3, 3, 1).
- `done` is high in the cycle after edge E0+k. `ready` returns in the cycle after that.
- Throughput: one operation per k+2 cycles.
- The clock period must exceed the `ari_shift` NAND-chain delay plus register setup. At 7ns per gate, the clock period is at least 100ns.

## Structure
- Package `shift_seq_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_t`;
  - `localparam CHUNK_MAX = 3`;
  - `localparam AMT_W = 3`;
  - `localparam DATA_W = 8`.
- There is one sub-module: the `ari_shift` instance (`#(NAND_TIME)`). Chunk computation and the FSM stay inline.

## Test plan
- Arithmetic right shift: `data`=0x81, `left`=0, `rotate`=0, `amt`=5 → chunks 3 then 2. `done` occurs 2 cycles after accept with `result`=0xFC.
- Left rotate: `data`=0x81, `left`=1, `rotate`=1, `amt`=7 → 3 SHIFT cycles, `result`=0xC0.
- Logical left shift and right rotate:
  - `data`=0x81, `left`=1, `rotate`=0, `amt`=4 → `result`=0x10.
  - `data`=0x96, right rotate, `amt`=3 → `result`=0xD2 after 1 SHIFT cycle.
- Zero distance: `amt`=0, `data`=0x5A → `done` in the cycle after accept, `result`=0x5A, no SHIFT cycles.
- Busy requests: while busy, assert `req` every cycle with different `data` → those requests are ignored. The first result is unchanged, and a new accept happens only after `ready` is high again.
- Reset mid-operation: assert `rst` in the second SHIFT cycle of an `amt`=7 operation → next cycle shows `ready`=1, `done`=0, `result`=0x00, and no `done` ever appears for the aborted operation.
